iob_cache_fe_arbiter: RTL and testbench

Round-robin arbiter that shares the single native front-end port of `iob_cache` between `N_REQ` requesters, e.g. an instruction fetch unit and a load/store unit. It registers the winning request and holds it stable on the cache port until the cache answers with `ready`. It then routes `rdata`/`ready` back to the granted requester only. It sits between the CPU-side masters and the cache `valid/addr/wdata/wstrb/rdata/ready` port.

---
 rtl/iob_cache_fe_arbiter_pkg.sv | 19 +
 rtl/iob_cache_fe_arbiter_picker.sv | 40 ++++
 rtl/iob_cache_fe_arbiter.sv | 110 +++++++++++
 tb/tb_iob_cache_fe_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iob_cache_fe_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | iob_cache_fe_arbiter_pkg: shared state encoding and index width      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package iob_cache_fe_arbiter_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    // Index width that never collapses to zero for small requester counts.
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/iob_cache_fe_arbiter_picker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | iob_rr_picker: combinational round-robin select starting at ptr_i    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module iob_rr_picker
    import iob_cache_fe_arbiter_pkg::*;
#(
    parameter int   N_REQ = 2,
    localparam int  IDX_W = idx_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [IDX_W-1:0] gnt_idx_o,
    output logic             any_o
);

    localparam logic [IDX_W:0] c_n_req = (IDX_W+1)'(N_REQ);

    logic [IDX_W:0] w_cand;

    // Scan offsets high to low so the closest requester at or above ptr wins.
    always_comb begin
        gnt_idx_o = '0;
        any_o     = 1'b0;
        w_cand    = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            w_cand = {1'b0, ptr_i} + (IDX_W+1)'(i);
            if (w_cand >= c_n_req) begin
                w_cand = w_cand - c_n_req;
            end
            if (req_i[w_cand[IDX_W-1:0]]) begin
                gnt_idx_o = w_cand[IDX_W-1:0];
                any_o     = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/iob_cache_fe_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | iob_cache_fe_arbiter: round-robin sharing of the cache front-end     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module iob_cache_fe_arbiter
    import iob_cache_fe_arbiter_pkg::*;
#(
    parameter int   N_REQ  = 2,
    parameter int   ADDR_W = 31,
    parameter int   DATA_W = 32,
    localparam int  IDX_W  = idx_w(N_REQ),
    localparam int  STRB_W = DATA_W / 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          s_valid,
    input  logic [N_REQ*ADDR_W-1:0]   s_addr,
    input  logic [N_REQ*DATA_W-1:0]   s_wdata,
    input  logic [N_REQ*STRB_W-1:0]   s_wstrb,
    output logic [DATA_W-1:0]         s_rdata,
    output logic [N_REQ-1:0]          s_ready,
    output logic                      c_valid,
    output logic [ADDR_W-1:0]         c_addr,
    output logic [DATA_W-1:0]         c_wdata,
    output logic [STRB_W-1:0]         c_wstrb,
    input  logic [DATA_W-1:0]         c_rdata,
    input  logic                      c_ready,
    output logic [IDX_W-1:0]          grant
);

    arb_state_t         state_q;
    logic [IDX_W-1:0]   ptr_q;
    logic [IDX_W-1:0]   grant_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  wdata_q;
    logic [STRB_W-1:0]  wstrb_q;

    logic [ADDR_W-1:0]  w_addr_arr  [N_REQ];
    logic [DATA_W-1:0]  w_wdata_arr [N_REQ];
    logic [STRB_W-1:0]  w_wstrb_arr [N_REQ];

    logic               w_done;
    logic [N_REQ-1:0]   w_owner_oh;
    logic [N_REQ-1:0]   w_elig;
    logic [IDX_W-1:0]   w_ptr_next;
    logic [IDX_W-1:0]   w_ptr_sel;
    logic [IDX_W-1:0]   w_win;
    logic               w_any;

    for (genvar k = 0; k < N_REQ; k++) begin : g_unpack
        assign w_addr_arr[k]  = s_addr[k*ADDR_W +: ADDR_W];
        assign w_wdata_arr[k] = s_wdata[k*DATA_W +: DATA_W];
        assign w_wstrb_arr[k] = s_wstrb[k*STRB_W +: STRB_W];
    end

    assign w_done     = (state_q == ARB_BUSY) && c_ready;
    assign w_owner_oh = N_REQ'(1) << grant_q;
    assign w_ptr_next = (grant_q == IDX_W'(N_REQ - 1)) ? '0 : grant_q + IDX_W'(1);

    // The completing owner still shows valid this cycle, so it is masked out
    // and the picker already uses the advanced pointer for a back-to-back win.
    assign w_elig     = s_valid & ~(w_done ? w_owner_oh : '0);
    assign w_ptr_sel  = w_done ? w_ptr_next : ptr_q;

    iob_rr_picker #(
        .N_REQ     (N_REQ)
    ) u_picker (
        .req_i     (w_elig),
        .ptr_i     (w_ptr_sel),
        .gnt_idx_o (w_win),
        .any_o     (w_any)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ARB_IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
        end else begin
            if (w_done) begin
                ptr_q <= w_ptr_next;
            end
            if ((state_q == ARB_IDLE) || w_done) begin
                if (w_any) begin
                    state_q <= ARB_BUSY;
                    grant_q <= w_win;
                    addr_q  <= w_addr_arr[w_win];
                    wdata_q <= w_wdata_arr[w_win];
                    wstrb_q <= w_wstrb_arr[w_win];
                end else begin
                    state_q <= ARB_IDLE;
                end
            end
        end
    end

    assign c_valid = (state_q == ARB_BUSY);
    assign c_addr  = addr_q;
    assign c_wdata = wdata_q;
    assign c_wstrb = wstrb_q;
    assign grant   = grant_q;
    assign s_ready = w_done ? w_owner_oh : '0;
    assign s_rdata = c_rdata;

endmodule
`default_nettype wire

// File: tb/tb_iob_cache_fe_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_iob_cache_fe_arbiter: directed bench with a transaction model     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_iob_cache_fe_arbiter;

    localparam int N  = 2;
    localparam int AW = 31;
    localparam int DW = 32;
    localparam int SW = 4;

    logic            clk   = 1'b0;
    logic            reset = 1'b1;
    logic [N-1:0]    s_valid;
    logic [N*AW-1:0] s_addr;
    logic [N*DW-1:0] s_wdata;
    logic [N*SW-1:0] s_wstrb;
    logic [DW-1:0]   s_rdata;
    logic [N-1:0]    s_ready;
    logic            c_valid;
    logic [AW-1:0]   c_addr;
    logic [DW-1:0]   c_wdata;
    logic [SW-1:0]   c_wstrb;
    logic [DW-1:0]   c_rdata;
    logic            c_ready;
    logic [0:0]      grant;

    always #5 clk = ~clk;

    iob_cache_fe_arbiter #(
        .N_REQ  (N),
        .ADDR_W (AW),
        .DATA_W (DW)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .s_valid (s_valid),
        .s_addr  (s_addr),
        .s_wdata (s_wdata),
        .s_wstrb (s_wstrb),
        .s_rdata (s_rdata),
        .s_ready (s_ready),
        .c_valid (c_valid),
        .c_addr  (c_addr),
        .c_wdata (c_wdata),
        .c_wstrb (c_wstrb),
        .c_rdata (c_rdata),
        .c_ready (c_ready),
        .grant   (grant)
    );

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [SW-1:0] wstrb;
    } txn_t;

    txn_t rq0[$];
    txn_t rq1[$];
    int   checks = 0;
    int   errors = 0;

    function automatic txn_t mk(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
        txn_t t;
        t.addr = a; t.wdata = d; t.wstrb = s;
        return t;
    endfunction

    function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual 0x%0h required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: who owns the cache port and what it asked for.
    int   m_owner = -1;
    int   m_ptr   = 0;
    int   m_grant = 0;
    txn_t m_req   = '0;

    function automatic txn_t req_of(input int k);
        return mk(s_addr[k*AW +: AW], s_wdata[k*DW +: DW], s_wstrb[k*SW +: SW]);
    endfunction

    always @(posedge clk or posedge reset) begin
        int excl;
        if (reset) begin
            m_owner = -1; m_ptr = 0; m_grant = 0; m_req = '0;
        end else begin
            excl = -1;
            if (m_owner >= 0 && c_ready) begin
                excl    = m_owner;
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
            end
            if (m_owner < 0) begin
                for (int off = 0; off < N; off++) begin
                    int k;
                    k = (m_ptr + off) % N;
                    if (m_owner < 0 && s_valid[k] && k != excl) begin
                        m_owner = k;
                        m_grant = k;
                        m_req   = req_of(k);
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [N-1:0] exp_rdy;
        exp_rdy = (m_owner >= 0 && c_ready) ? (N'(1) << m_owner) : '0;
        chk("c_valid", c_valid, m_owner >= 0);
        chk("s_ready", s_ready, exp_rdy);
        chk("grant", grant, m_grant);
        if (m_owner >= 0) begin
            chk("c_addr", c_addr, m_req.addr);
            chk("c_wdata", c_wdata, m_req.wdata);
            chk("c_wstrb", c_wstrb, m_req.wstrb);
        end
        if (exp_rdy != '0) begin
            chk("s_rdata", s_rdata, mem_rd(m_req.addr));
        end
    end

    // Requester/cache environment and per-phase observations.
    logic [N-1:0]  snap_rdy;
    int            cnt = 0;
    int            lat = 3;
    int            done_q[$];
    logic [AW-1:0] done_addr[$];
    logic [DW-1:0] done_data[$];
    int            cv_cycles, gap_cycles, idle_run;
    bit            seen_busy;

    function automatic int dq(input int i);
        return (i < done_q.size()) ? done_q[i] : -1;
    endfunction
    function automatic logic [AW-1:0] da(input int i);
        return (i < done_addr.size()) ? done_addr[i] : '1;
    endfunction
    function automatic logic [DW-1:0] dd(input int i);
        return (i < done_data.size()) ? done_data[i] : '1;
    endfunction

    task automatic clr();
        cv_cycles = 0; gap_cycles = 0; idle_run = 0; seen_busy = 0;
        done_q.delete(); done_addr.delete(); done_data.delete();
    endtask

    task automatic drive_reqs();
        s_valid[0] = rq0.size() > 0;
        s_valid[1] = rq1.size() > 0;
        if (rq0.size() > 0) begin
            s_addr[0 +: AW] = rq0[0].addr; s_wdata[0 +: DW] = rq0[0].wdata; s_wstrb[0 +: SW] = rq0[0].wstrb;
        end
        if (rq1.size() > 0) begin
            s_addr[AW +: AW] = rq1[0].addr; s_wdata[DW +: DW] = rq1[0].wdata; s_wstrb[SW +: SW] = rq1[0].wstrb;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        snap_rdy = s_ready;
        if (c_valid) begin
            cv_cycles++;
            if (seen_busy) gap_cycles += idle_run;
            idle_run  = 0;
            seen_busy = 1;
        end else if (seen_busy) begin
            idle_run++;
        end
        for (int k = 0; k < N; k++) begin
            if (s_ready[k]) begin
                done_q.push_back(k);
                done_addr.push_back(c_addr);
                done_data.push_back(s_rdata);
            end
        end
        @(posedge clk);
        #1;
        if (snap_rdy[0] && rq0.size() > 0) void'(rq0.pop_front());
        if (snap_rdy[1] && rq1.size() > 0) void'(rq1.pop_front());
        drive_reqs();
        if (c_ready) begin
            c_ready = 1'b0;
            cnt     = 0;
        end
        c_rdata = 32'hBAD0_0000 | DW'(cnt);
        if (c_valid) begin
            cnt++;
            if (cnt >= lat) begin
                c_ready = 1'b1;
                c_rdata = mem_rd(c_addr);
            end
        end
    endtask

    task automatic run_idle(input string name, input int max);
        int n;
        n = 0;
        do begin
            cycle();
            n++;
        end while ((rq0.size() > 0 || rq1.size() > 0 || c_valid) && n < max);
        if (rq0.size() > 0 || rq1.size() > 0 || c_valid) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: actual busy after %0d cycles required idle", name, n);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual time limit reached required finish");
        $fatal(1);
    end

    initial begin
        s_valid = '0; s_addr = '0; s_wdata = '0; s_wstrb = '0;
        c_ready = 1'b0; c_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_c_valid", c_valid, 0);
        chk("rst_c_addr", c_addr, 0);
        chk("rst_c_wdata", c_wdata, 0);
        chk("rst_c_wstrb", c_wstrb, 0);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_grant", grant, 0);
        reset = 1'b0;

        // Two reads presented together from IDLE with ptr at 0.
        clr(); lat = 2;
        rq0.push_back(mk(31'h10, 32'h0, 4'h0));
        rq1.push_back(mk(31'h20, 32'h0, 4'h0));
        drive_reqs();
        run_idle("t2", 40);
        chk("t2_n", done_q.size(), 2);
        chk("t2_first", dq(0), 0);
        chk("t2_second", dq(1), 1);
        chk("t2_addr0", da(0), 31'h10);
        chk("t2_addr1", da(1), 31'h20);
        chk("t2_data0", dd(0), 32'h0010FFEF);
        chk("t2_data1", dd(1), 32'h0020FFDF);
        chk("t2_gap", gap_cycles, 0);

        // Both requesters continuously valid for 8 transactions.
        clr(); lat = 1;
        for (int i = 0; i < 4; i++) begin
            rq0.push_back(mk(AW'(32'h100 + i*4), 32'h1000 + i, 4'h0));
            rq1.push_back(mk(AW'(32'h200 + i*4), 32'h2000 + i, 4'h3));
        end
        drive_reqs();
        run_idle("t3", 80);
        chk("t3_n", done_q.size(), 8);
        for (int i = 0; i < 8; i++) chk($sformatf("t3_order%0d", i), dq(i), i % 2);
        chk("t3_gap", gap_cycles, 0);

        // Single write from requester 0, cache answers on the third c_valid cycle.
        clr(); lat = 3;
        rq0.push_back(mk(31'h4, 32'hDEADBEEF, 4'hF));
        drive_reqs();
        run_idle("t1", 40);
        chk("t1_busy", cv_cycles, 3);
        chk("t1_n", done_q.size(), 1);
        chk("t1_who", dq(0), 0);
        chk("t1_addr", da(0), 31'h4);

        // Requester 0 alone, two reads back to back.
        clr(); lat = 2;
        rq0.push_back(mk(31'h30, 32'h0, 4'h0));
        rq0.push_back(mk(31'h34, 32'h0, 4'h0));
        drive_reqs();
        run_idle("t4", 40);
        chk("t4_gap", gap_cycles, 1);
        chk("t4_data0", dd(0), 32'h0030FFCF);
        chk("t4_data1", dd(1), 32'h0034FFCB);

        // c_ready pulsed while idle.
        c_ready = 1'b1;
        @(negedge clk);
        chk("t6_s_ready", s_ready, 0);
        @(posedge clk);
        #1;
        c_ready = 1'b0;
        @(negedge clk);
        chk("t6_c_valid", c_valid, 0);

        // Reset in the middle of a transaction that the cache never answers.
        @(posedge clk);
        #1;
        clr(); lat = 1000;
        rq0.push_back(mk(31'h40, 32'h0, 4'h0));
        drive_reqs();
        repeat (3) cycle();
        #2;
        reset = 1'b1;
        rq0.delete();
        drive_reqs();
        c_ready = 1'b0;
        cnt = 0;
        #1;
        chk("t5_c_valid", c_valid, 0);
        chk("t5_s_ready", s_ready, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        clr(); lat = 2;
        rq0.push_back(mk(31'h50, 32'h0, 4'h0));
        rq1.push_back(mk(31'h60, 32'h0, 4'h0));
        drive_reqs();
        run_idle("t5a", 40);
        chk("t5_first", dq(0), 0);
        chk("t5_second", dq(1), 1);
        clr();
        rq1.push_back(mk(31'h70, 32'h0, 4'h0));
        drive_reqs();
        run_idle("t5b", 40);
        chk("t5_r1_n", done_q.size(), 1);
        chk("t5_r1_who", dq(0), 1);
        chk("t5_grant", grant, 1);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
